// File: rtl/sdram_wb_bridge.sv
// Wishbone-to-SDRAM-controller bridge: controller reset sequencing, request
// latching with byte masks, read-data capture, delayed acknowledge and timeout.
module sdram_wb_bridge #(
  parameter int RST_DELAY = 3,
  parameter int ACK_DELAY = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_p,
  input  logic        reset,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [21:1] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        ctl_rst_n,
  input  logic        ctl_init_done,
  output logic        ready,
  output logic        ctl_wr_req,
  output logic        ctl_rd_req,
  input  logic        ctl_wr_ack,
  input  logic        ctl_rd_ack,
  input  logic [15:0] ctl_rdata,
  output logic [21:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  output logic [1:0]  ctl_be,
  output logic [1:0]  dqm,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ACKD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] RST_LIM = 8'(RST_DELAY);
  localparam logic [1:0] ACK_LD  = 2'(ACK_DELAY - 1);
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

  logic [7:0]  rcnt_q, rcnt_d;
  logic        rstn_q, rstn_d;
  logic        ready_q;
  state_t      state_q, state_d;
  logic [21:1] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [1:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  dly_q, dly_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        ack_q, ack_d;
  logic        abort_q, abort_d;
  logic        to_q, to_d;
  logic        ack_match_s;

  // Only the acknowledge matching the latched direction is honoured.
  assign ack_match_s = we_q ? ctl_wr_ack : ctl_rd_ack;

  // Controller reset release: count up after reset, saturate once released.
  always_comb begin
    rcnt_d = rcnt_q;
    rstn_d = rstn_q;
    if (rcnt_q != RST_LIM) begin
      rcnt_d = rcnt_q + 8'd1;
      rstn_d = ((rcnt_q + 8'd1) == RST_LIM);
    end else begin
      rstn_d = 1'b1;
    end
  end

  // Reset-sequencer and init-done synchroniser registers.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      rcnt_q  <= 8'd0;
      rstn_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      rstn_q  <= rstn_d;
      ready_q <= ctl_init_done;
    end
  end

  // Transaction FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    dqm_d    = dqm_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    rdata_d  = rdata_q;
    dly_d    = dly_q;
    tcnt_d   = tcnt_q;
    ack_d    = ack_q;
    abort_d  = abort_q;
    to_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        if (wb_stb && ready_q) begin
          adr_d    = wb_adr;
          dat_d    = wb_dat_i;
          sel_d    = wb_sel;
          we_d     = wb_we;
          dqm_d    = wb_we ? ~wb_sel : 2'b00;
          wr_req_d = wb_we;
          rd_req_d = ~wb_we;
          abort_d  = 1'b0;
          tcnt_d   = 8'd0;
          state_d  = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // Counter tracks cycles with the request asserted, REQ included.
        tcnt_d  = 8'd1;
        abort_d = abort_q | ~wb_stb;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        abort_d = abort_q | ~wb_stb;
        if (ack_match_s) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          rdata_d  = we_q ? rdata_q : ctl_rdata;
          dly_d    = ACK_LD;
          state_d  = S_ACKD;
        end else if (tcnt_q == (TO_LIM - 8'd1)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          ack_d    = 1'b0;
          to_d     = 1'b1;
          state_d  = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_ACKD: begin
        abort_d = abort_q | ~wb_stb;
        if (dly_q == 2'd0) begin
          ack_d   = wb_stb & ~abort_q;
          state_d = S_DONE;
        end else begin
          dly_d = dly_q - 2'd1;
        end
      end
      S_DONE: begin
        // An aborted strobe already ended; any new strobe is a new transaction.
        if (!wb_stb || abort_q) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        ack_d    = 1'b0;
      end
    endcase
  end

  // Transaction FSM and datapath registers.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      state_q  <= S_IDLE;
      adr_q    <= 21'd0;
      dat_q    <= 16'd0;
      sel_q    <= 2'b00;
      we_q     <= 1'b0;
      dqm_q    <= 2'b00;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      rdata_q  <= 16'd0;
      dly_q    <= 2'd0;
      tcnt_q   <= 8'd0;
      ack_q    <= 1'b0;
      abort_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      dqm_q    <= dqm_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      rdata_q  <= rdata_d;
      dly_q    <= dly_d;
      tcnt_q   <= tcnt_d;
      ack_q    <= ack_d;
      abort_q  <= abort_d;
      to_q     <= to_d;
    end
  end

  assign wb_ack     = ack_q & wb_stb;
  assign wb_dat_o   = rdata_q;
  assign ctl_rst_n  = rstn_q;
  assign ready      = ready_q;
  assign ctl_wr_req = wr_req_q;
  assign ctl_rd_req = rd_req_q;
  assign ctl_addr   = {1'b0, adr_q};
  assign ctl_wdata  = dat_q;
  assign ctl_be     = sel_q;
  assign dqm        = dqm_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_sdram_wb_bridge;

  logic        clk_p;
  logic        reset;
  logic        wb_stb, wb_we;
  logic [1:0]  wb_sel;
  logic [21:1] wb_adr;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack, ctl_rst_n, ctl_init_done, ready;
  logic        ctl_wr_req, ctl_rd_req, ctl_wr_ack, ctl_rd_ack;
  logic [15:0] ctl_rdata, ctl_wdata;
  logic [21:0] ctl_addr;
  logic [1:0]  ctl_be, dqm;
  logic        timeout;

  sdram_wb_bridge #(.RST_DELAY(3), .ACK_DELAY(2), .TIMEOUT(255)) dut (
    .clk_p(clk_p), .reset(reset), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .ctl_rst_n(ctl_rst_n), .ctl_init_done(ctl_init_done),
    .ready(ready), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
    .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_rdata(ctl_rdata),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_be(ctl_be), .dqm(dqm),
    .timeout(timeout)
  );

  localparam int K_WREQ = 0, K_RREQ = 1, K_RFALL = 2, K_ACK = 3;
  localparam int K_TO_R = 4, K_TO_F = 5, K_RSTN_R = 6, K_RSTN_F = 7;

  typedef struct {
    int          kind;
    int          at_cyc;
    bit          full;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [1:0]  dqm;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_rd;
  logic        p_wr, p_rd, p_ack, p_to, p_rn;

  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  always @(posedge clk_p) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_WREQ:   return "wr_req_rise";
      K_RREQ:   return "rd_req_rise";
      K_RFALL:  return "req_fall";
      K_ACK:    return "wb_ack_rise";
      K_TO_R:   return "timeout_rise";
      K_TO_F:   return "timeout_fall";
      K_RSTN_R: return "ctl_rst_n_rise";
      default:  return "ctl_rst_n_fall";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_p);
      #1;
    end
  endtask

  task automatic push(input int kind, input int at, input bit full, input logic [21:0] a,
                      input logic [15:0] wd, input logic [1:0] be, input logic [1:0] dm,
                      input logic [15:0] rd);
    exp_t e;
    e.kind = kind; e.at_cyc = at; e.full = full; e.addr = a;
    e.wdata = wd; e.be = be; e.dqm = dm; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic push_ev(input int kind, input int at);
    push(kind, at, 1'b0, 22'd0, 16'd0, 2'b00, 2'b00, 16'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, want, cyc);
  endtask

  task automatic handle(input int kind);
    int          idx;
    exp_t        e;
    logic [55:0] got_f, want_f;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      $display("FAIL unexpected %s at cycle %0d", kname(kind), cyc);
    end else begin
      e = sb[idx];
      sb.delete(idx);
      got_f  = {ctl_addr, ctl_wdata, ctl_be, dqm, wb_dat_o};
      want_f = {e.addr, e.wdata, e.be, e.dqm, e.rdata};
      if ((e.at_cyc >= 0 && e.at_cyc != cyc) || (e.full && got_f !== want_f))
        $display("FAIL %s: cycle %0d fields %h, expected cycle %0d fields %h",
                 kname(kind), cyc, got_f, e.at_cyc, want_f);
      else
        passes++;
    end
  endtask

  // Edge detector on the DUT outputs, sampled away from the active edge.
  always @(negedge clk_p) begin
    if (p_rn === 1'b0 && ctl_rst_n === 1'b1) handle(K_RSTN_R);
    if (p_rn === 1'b1 && ctl_rst_n === 1'b0) handle(K_RSTN_F);
    if (p_wr === 1'b0 && ctl_wr_req === 1'b1) handle(K_WREQ);
    if (p_rd === 1'b0 && ctl_rd_req === 1'b1) handle(K_RREQ);
    if ((p_wr === 1'b1 && ctl_wr_req === 1'b0) || (p_rd === 1'b1 && ctl_rd_req === 1'b0))
      handle(K_RFALL);
    if (p_ack === 1'b0 && wb_ack === 1'b1) handle(K_ACK);
    if (p_to === 1'b0 && timeout === 1'b1) handle(K_TO_R);
    if (p_to === 1'b1 && timeout === 1'b0) handle(K_TO_F);
    p_rn = ctl_rst_n; p_wr = ctl_wr_req; p_rd = ctl_rd_req; p_ack = wb_ack; p_to = timeout;
  end

  initial begin
    int q;
    reset = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00; wb_adr = 21'd0;
    wb_dat_i = 16'd0; ctl_init_done = 1'b1; ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0;
    ctl_rdata = 16'd0; exp_rd = 16'd0;

    // Reset values, then release sequencing.
    tick(2);
    chk("reset_outputs", 32'({ctl_rst_n, ready, ctl_wr_req, ctl_rd_req, wb_ack, timeout, dqm, wb_dat_o}), 32'd0);
    tick(3);
    reset = 1'b0;
    push_ev(K_RSTN_R, cyc + 3);
    tick(6);

    // Write with mid-transaction input changes.
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b10; wb_adr = 21'h012345; wb_dat_i = 16'hBEEF;
    push(K_WREQ, cyc + 1, 1'b1, 22'h012345, 16'hBEEF, 2'b10, 2'b01, exp_rd);
    tick(3);
    wb_adr = 21'h1AAAAA; wb_dat_i = 16'h0000; wb_sel = 2'b11; wb_we = 1'b0;
    tick(1);
    ctl_wr_ack = 1'b1;
    push_ev(K_RFALL, cyc + 1);
    push(K_ACK, cyc + 3, 1'b1, 22'h012345, 16'hBEEF, 2'b10, 2'b01, exp_rd);
    tick(1);
    ctl_wr_ack = 1'b0;
    tick(4);
    chk("wr_ack_held", 32'(wb_ack), 32'd1);
    wb_stb = 1'b0;
    #1;
    chk("wr_ack_masked_by_stb", 32'(wb_ack), 32'd0);
    tick(2);

    // Read; a lone wr_ack is ignored, simultaneous acks honour rd_ack.
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b01; wb_adr = 21'h000ABC; wb_dat_i = 16'h5555;
    push(K_RREQ, cyc + 1, 1'b1, 22'h000ABC, 16'h5555, 2'b01, 2'b00, exp_rd);
    tick(2);
    ctl_wr_ack = 1'b1;
    tick(1);
    ctl_rd_ack = 1'b1; ctl_rdata = 16'h1234;
    exp_rd = 16'h1234;
    push_ev(K_RFALL, cyc + 1);
    push(K_ACK, cyc + 3, 1'b1, 22'h000ABC, 16'h5555, 2'b01, 2'b00, exp_rd);
    tick(1);
    ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_rdata = 16'hFFFF;
    tick(4);
    wb_stb = 1'b0;
    tick(2);

    // Not ready: strobe held, nothing happens until init_done returns.
    ctl_init_done = 1'b0;
    tick(1);
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b01; wb_adr = 21'h1FFFFF; wb_dat_i = 16'h00FF;
    tick(20);
    chk("notready_idle", 32'({ctl_wr_req, ctl_rd_req, wb_ack}), 32'd0);
    ctl_init_done = 1'b1;
    push(K_WREQ, cyc + 2, 1'b1, 22'h1FFFFF, 16'h00FF, 2'b01, 2'b10, exp_rd);
    tick(4);
    ctl_wr_ack = 1'b1;
    push_ev(K_RFALL, cyc + 1);
    push(K_ACK, cyc + 3, 1'b1, 22'h1FFFFF, 16'h00FF, 2'b01, 2'b10, exp_rd);
    tick(1);
    ctl_wr_ack = 1'b0;
    tick(4);
    wb_stb = 1'b0;
    tick(2);

    // Timeout: read never acknowledged, request high for 255 cycles.
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h000001; wb_dat_i = 16'hA5A5;
    push(K_RREQ, cyc + 1, 1'b1, 22'h000001, 16'hA5A5, 2'b11, 2'b00, exp_rd);
    push_ev(K_RFALL, cyc + 256);
    push_ev(K_TO_R, cyc + 256);
    push_ev(K_TO_F, cyc + 257);
    tick(262);
    chk("timeout_no_ack", 32'(wb_ack), 32'd0);
    wb_stb = 1'b0;
    tick(2);

    // Master abort in WAIT, then a fresh write two cycles after the ack.
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b10; wb_adr = 21'h0F0F0F; wb_dat_i = 16'h1111;
    push(K_RREQ, cyc + 1, 1'b1, 22'h0F0F0F, 16'h1111, 2'b10, 2'b00, exp_rd);
    tick(3);
    wb_stb = 1'b0;
    tick(2);
    ctl_rd_ack = 1'b1; ctl_rdata = 16'hCAFE;
    exp_rd = 16'hCAFE;
    push_ev(K_RFALL, cyc + 1);
    tick(1);
    ctl_rd_ack = 1'b0;
    tick(1);
    wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_adr = 21'h000000; wb_dat_i = 16'h7E57;
    push(K_WREQ, -1, 1'b1, 22'h000000, 16'h7E57, 2'b11, 2'b00, exp_rd);
    for (int i = 0; i < 20; i++) begin
      if (ctl_wr_req === 1'b1) break;
      tick(1);
    end
    chk("abort_new_req_started", 32'(ctl_wr_req), 32'd1);
    tick(2);
    ctl_wr_ack = 1'b1;
    q = cyc;
    push_ev(K_RFALL, q + 1);
    push(K_ACK, q + 3, 1'b1, 22'h000000, 16'h7E57, 2'b11, 2'b00, exp_rd);
    tick(1);
    ctl_wr_ack = 1'b0;
    tick(4);
    wb_stb = 1'b0;
    tick(2);

    // Reset pulse mid-transaction.
    wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b01; wb_adr = 21'h055555; wb_dat_i = 16'h0000;
    push(K_RREQ, cyc + 1, 1'b1, 22'h055555, 16'h0000, 2'b01, 2'b00, exp_rd);
    tick(3);
    reset = 1'b1; wb_stb = 1'b0;
    push_ev(K_RSTN_F, cyc + 1);
    push_ev(K_RFALL, cyc + 1);
    tick(1);
    chk("midreset_outputs", 32'({ready, dqm, wb_dat_o}), 32'd0);
    reset = 1'b0;
    push_ev(K_RSTN_R, cyc + 3);
    tick(8);

    while (sb.size() > 0) begin
      checks++;
      $display("FAIL missing %s expected at cycle %0d", kname(sb[0].kind), sb[0].at_cyc);
      sb.delete(0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdram_wb_bridge.md
Name: sdram_wb_bridge

Overview:
- Bridge between the kernel's Wishbone-style SDRAM port (stb/we/sel/adr/dat/ack) and the req/ack interface of the SDRAM controller core.
- Sits between topboard and sdram_top.
- Replaces ad-hoc board glue with one synchronous block:
  - controller reset release sequencing;
  - request latching and byte-mask generation;
  - read-data capture;
  - delayed acknowledge;
  - transaction timeout.

Parameters:
- RST_DELAY, 3: clk_p cycles after reset deasserts before ctl_rst_n goes high.
- ACK_DELAY, 2: cycles from controller ack to wb_ack (1..3).
- TIMEOUT, 255: max cycles in WAIT before abort (8-bit counter).

Ports:
- clk_p  in  1  system clock, 100 MHz, all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- wb_stb  in  1  transaction strobe.
- wb_we  in  1  1 = write.
- wb_sel  in  2  byte selects [1] = high byte, [0] = low byte.
- wb_adr  in  21  word address [21:1].
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_ack  out  1  transaction acknowledge.
- ctl_rst_n  out  1  controller reset, active-low.
- ctl_init_done  in  1  controller initialisation complete.
- ready  out  1  registered copy of ctl_init_done.
- ctl_wr_req  out  1  write request.
- ctl_rd_req  out  1  read request.
- ctl_wr_ack  in  1  write accepted/complete.
- ctl_rd_ack  in  1  read data valid.
- ctl_addr  out  22  {1'b0, latched wb_adr}.
- ctl_wdata  out  16  latched write data.
- ctl_be  out  2  latched wb_sel.
- dqm  out  2  SDRAM {UDQM, LDQM}.
- timeout  out  1  one-cycle pulse on aborted transaction.

Behaviour:

Reset values (while reset = 1), next edge:
- ctl_rst_n = 0, rst counter = 0, ready = 0.
- FSM = IDLE, all req = 0, wb_ack = 0, wb_dat_o = 0, dqm = 2'b00, timeout = 0.

Reset sequencing:
- After reset falls, the counter increments each cycle.
- ctl_rst_n rises on the cycle the counter reaches RST_DELAY and stays high.
- Reset reasserted at any time immediately zeroes ctl_rst_n and the counter. This includes mid-transaction, where the FSM also aborts to IDLE with no wb_ack.

FSM states: IDLE, REQ, WAIT, ACKD, DONE.
- IDLE:
  - If wb_stb = 1 and ready = 1: latch adr, dat_i, sel, we. Set dqm = we ? ~sel : 2'b00 (reads are always full-word). Go to REQ.
  - If wb_stb = 1 and ready = 0: hold in IDLE. No req, no ack.
- REQ:
  - Assert ctl_wr_req (we = 1) or ctl_rd_req (we = 0).
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - The request stays asserted until the matching ack (ctl_wr_ack for writes, ctl_rd_ack for reads) is sampled high.
  - On that cycle: deassert req. On reads, capture ctl_rdata into wb_dat_o. Load the delay counter with ACK_DELAY-1. Go to ACKD.
  - The non-matching ack is ignored.
  - If the counter reaches TIMEOUT: deassert req, pulse timeout for 1 cycle, go to DONE with no wb_ack.
- ACKD:
  - Count down. At 0, assert wb_ack if wb_stb = 1, then go to DONE.
  - If wb_stb dropped earlier (master abort), the SDRAM op still completes and wb_ack stays 0.
- DONE:
  - Hold wb_ack = wb_stb & (arrived via ACKD).
  - Return to IDLE when wb_stb = 0. This guarantees one transaction per strobe.

Timing and data rules:
- Latency: wb_ack rises ACK_DELAY+1 cycles after the controller ack cycle.
- wb_ack is combinationally masked by wb_stb, so it never appears without stb.
- wb_dat_o holds its value until the next read capture.
- dqm changes only in IDLE on acceptance.
- Inputs are not re-sampled during a transaction. Changes of adr/dat/sel/we mid-transaction have no effect.
- Simultaneous ctl_wr_ack and ctl_rd_ack: only the one matching the latched we is honoured.

Test Plan:
- Reset/sequencing: reset high 5 cycles, then low. ctl_rst_n rises exactly 3 cycles later. Pulsing reset 1 cycle mid-run drops ctl_rst_n the next edge and restarts the count.
- Write: ready = 1, stb with we = 1, sel = 2'b10, adr = 21'h012345, dat = 16'hBEEF.
  - Next cycles: ctl_wr_req = 1, ctl_addr = 22'h012345, ctl_wdata = BEEF, dqm = 2'b01.
  - ctl_wr_ack at cycle N gives wb_ack at N+3, held until stb drops.
- Read: stb with we = 0, sel = 2'b01. dqm = 2'b00. ctl_rd_ack with ctl_rdata = 16'h1234 gives wb_dat_o = 1234 and wb_ack 3 cycles later.
- Not ready: ctl_init_done = 0 with stb held 20 cycles gives no req and no ack. Raising init_done starts the request 2 cycles later (sync + IDLE).
- Timeout: read with no ack. Req stays high 255 cycles, then drops, timeout pulses once, wb_ack never rises. FSM returns to IDLE after stb drops.
- Abort: stb drops in WAIT. After ctl_rd_ack, no wb_ack. A new stb two cycles later starts a fresh, correct transaction.
